// File: rtl/matmul_apb_arbiter.sv
// Two-requester APB master for the matmul slave: round-robin grant, SETUP/ACCESS
// sequencing, and a watchdog that aborts accesses whose pready never arrives.
module matmul_apb_arbiter #(
    parameter int BUS_WIDTH  = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int MAX_DIM    = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [1:0]              req_i,
    input  logic [1:0]              write_i,
    input  logic [2*ADDR_WIDTH-1:0] addr_i,
    input  logic [2*BUS_WIDTH-1:0]  wdata_i,
    input  logic [2*MAX_DIM-1:0]    strb_i,
    output logic [1:0]              done_o,
    output logic                    err_o,
    output logic [BUS_WIDTH-1:0]    rdata_o,
    output logic [ADDR_WIDTH-1:0]   paddr_o,
    output logic                    psel_o,
    output logic                    penable_o,
    output logic                    pwrite_o,
    output logic [BUS_WIDTH-1:0]    pwdata_o,
    output logic [MAX_DIM-1:0]      pstrb_o,
    input  logic [BUS_WIDTH-1:0]    prdata_i,
    input  logic                    pready_i,
    input  logic                    pslverr_i
);
    localparam int              CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    generate
        if (TIMEOUT < 2) begin : g_bad_timeout
            $error("matmul_apb_arbiter: TIMEOUT must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_prio;
    logic                  r_win;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_psel;
    logic                  r_penable;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic                  r_pwrite;
    logic [BUS_WIDTH-1:0]  r_pwdata;
    logic [MAX_DIM-1:0]    r_pstrb;
    logic [1:0]            r_done;
    logic                  r_err;
    logic [BUS_WIDTH-1:0]  r_rdata;

    state_t                w_state_nxt;
    logic                  w_prio_nxt;
    logic                  w_win_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  w_psel_nxt;
    logic                  w_penable_nxt;
    logic [ADDR_WIDTH-1:0] w_paddr_nxt;
    logic                  w_pwrite_nxt;
    logic [BUS_WIDTH-1:0]  w_pwdata_nxt;
    logic [MAX_DIM-1:0]    w_pstrb_nxt;
    logic [1:0]            w_done_nxt;
    logic                  w_err_nxt;
    logic [BUS_WIDTH-1:0]  w_rdata_nxt;

    logic [1:0]            w_req_eff;
    logic                  w_gnt;
    logic                  w_gnt_write;
    logic [ADDR_WIDTH-1:0] w_gnt_addr;
    logic [BUS_WIDTH-1:0]  w_gnt_wdata;
    logic [MAX_DIM-1:0]    w_gnt_strb;

    // The requester being told it is done still shows its stale req_i this cycle.
    assign w_req_eff   = req_i & ~r_done;
    assign w_gnt       = (w_req_eff == 2'b11) ? r_prio : w_req_eff[1];
    assign w_gnt_write = write_i[w_gnt];
    assign w_gnt_addr  = w_gnt ? addr_i[ADDR_WIDTH +: ADDR_WIDTH] : addr_i[0 +: ADDR_WIDTH];
    assign w_gnt_wdata = w_gnt ? wdata_i[BUS_WIDTH +: BUS_WIDTH] : wdata_i[0 +: BUS_WIDTH];
    assign w_gnt_strb  = w_gnt ? strb_i[MAX_DIM +: MAX_DIM] : strb_i[0 +: MAX_DIM];

    always_comb begin
        // NOTE: every target gets a default first so no path leaves a latch behind.
        w_state_nxt   = r_state;
        w_prio_nxt    = r_prio;
        w_win_nxt     = r_win;
        w_cnt_nxt     = r_cnt;
        w_psel_nxt    = r_psel;
        w_penable_nxt = r_penable;
        w_paddr_nxt   = r_paddr;
        w_pwrite_nxt  = r_pwrite;
        w_pwdata_nxt  = r_pwdata;
        w_pstrb_nxt   = r_pstrb;
        w_done_nxt    = '0;
        w_err_nxt     = 1'b0;
        w_rdata_nxt   = '0;

        unique case (r_state)
            S_IDLE: begin
                if (|w_req_eff) begin
                    w_state_nxt   = S_SETUP;
                    w_win_nxt     = w_gnt;
                    w_psel_nxt    = 1'b1;
                    w_penable_nxt = 1'b0;
                    w_paddr_nxt   = w_gnt_addr;
                    w_pwrite_nxt  = w_gnt_write;
                    w_pwdata_nxt  = w_gnt_wdata;
                    w_pstrb_nxt   = w_gnt_write ? w_gnt_strb : '0;
                end
            end
            S_SETUP: begin
                w_state_nxt   = S_ACCESS;
                w_penable_nxt = 1'b1;
                w_cnt_nxt     = '0;
            end
            S_ACCESS: begin
                if (pready_i || (r_cnt == CNT_LAST)) begin
                    w_state_nxt   = S_IDLE;
                    w_prio_nxt    = ~r_win;
                    w_cnt_nxt     = '0;
                    w_psel_nxt    = 1'b0;
                    w_penable_nxt = 1'b0;
                    w_paddr_nxt   = '0;
                    w_pwrite_nxt  = 1'b0;
                    w_pwdata_nxt  = '0;
                    w_pstrb_nxt   = '0;
                    w_done_nxt    = {r_win, ~r_win};
                    // A watchdog abort reports an error and never forwards prdata.
                    w_err_nxt     = pready_i ? pslverr_i : 1'b1;
                    w_rdata_nxt   = (pready_i && !r_pwrite) ? prdata_i : '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state is updated with non-blocking assignments so every register
        // sees the pre-edge values of its neighbours.
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_prio    <= 1'b0;
            r_win     <= 1'b0;
            r_cnt     <= '0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_paddr   <= '0;
            r_pwrite  <= 1'b0;
            r_pwdata  <= '0;
            r_pstrb   <= '0;
            r_done    <= '0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_prio    <= w_prio_nxt;
            r_win     <= w_win_nxt;
            r_cnt     <= w_cnt_nxt;
            r_psel    <= w_psel_nxt;
            r_penable <= w_penable_nxt;
            r_paddr   <= w_paddr_nxt;
            r_pwrite  <= w_pwrite_nxt;
            r_pwdata  <= w_pwdata_nxt;
            r_pstrb   <= w_pstrb_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_rdata   <= w_rdata_nxt;
        end
    end

    assign done_o    = r_done;
    assign err_o     = r_err;
    assign rdata_o   = r_rdata;
    assign paddr_o   = r_paddr;
    assign psel_o    = r_psel;
    assign penable_o = r_penable;
    assign pwrite_o  = r_pwrite;
    assign pwdata_o  = r_pwdata;
    assign pstrb_o   = r_pstrb;

endmodule

// File: tb/tb_matmul_apb_arbiter.sv
// Bench for matmul_apb_arbiter: directed scenarios with literal expectations, then
// random traffic, all cross-checked every cycle against a transaction-level model.
module tb_matmul_apb_arbiter;
    localparam int BW = 32;
    localparam int AW = 16;
    localparam int SW = 4;
    localparam int TO = 16;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [1:0]      req_i;
    logic [1:0]      write_i;
    logic [2*AW-1:0] addr_i;
    logic [2*BW-1:0] wdata_i;
    logic [2*SW-1:0] strb_i;
    logic [1:0]      done_o;
    logic            err_o;
    logic [BW-1:0]   rdata_o;
    logic [AW-1:0]   paddr_o;
    logic            psel_o;
    logic            penable_o;
    logic            pwrite_o;
    logic [BW-1:0]   pwdata_o;
    logic [SW-1:0]   pstrb_o;
    logic [BW-1:0]   prdata_i;
    logic            pready_i;
    logic            pslverr_i;

    int n_checks = 0;
    int n_fail   = 0;

    matmul_apb_arbiter #(
        .BUS_WIDTH (BW),
        .ADDR_WIDTH(AW),
        .MAX_DIM   (SW),
        .TIMEOUT   (TO)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (req_i),
        .write_i  (write_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .strb_i   (strb_i),
        .done_o   (done_o),
        .err_o    (err_o),
        .rdata_o  (rdata_o),
        .paddr_o  (paddr_o),
        .psel_o   (psel_o),
        .penable_o(penable_o),
        .pwrite_o (pwrite_o),
        .pwdata_o (pwdata_o),
        .pstrb_o  (pstrb_o),
        .prdata_i (prdata_i),
        .pready_i (pready_i),
        .pslverr_i(pslverr_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: who owns the bus, how many ACCESS cycles it has
    // spent, and what each output must read in the following cycle.
    bit              m_busy      = 0;
    bit              m_in_access = 0;
    int              m_win       = 0;
    int              m_prio      = 0;
    int              m_acc       = 0;
    logic [1:0]      m_mask      = '0;
    logic            e_psel      = 0;
    logic            e_pen       = 0;
    logic            e_pwrite    = 0;
    logic [AW-1:0]   e_paddr     = '0;
    logic [BW-1:0]   e_pwdata    = '0;
    logic [SW-1:0]   e_pstrb     = '0;
    logic [1:0]      e_done      = '0;
    logic            e_err       = 0;
    logic [BW-1:0]   e_rdata     = '0;

    always @(posedge clk_i) begin : model
        logic [1:0] want;
        e_done  = '0;
        e_err   = 1'b0;
        e_rdata = '0;
        if (rst_i) begin
            m_busy = 0; m_in_access = 0; m_prio = 0; m_acc = 0; m_mask = '0;
            e_psel = 0; e_pen = 0; e_pwrite = 0; e_paddr = '0; e_pwdata = '0; e_pstrb = '0;
        end else if (!m_busy) begin
            want   = req_i & ~m_mask;
            m_mask = '0;
            if (want != 2'b00) begin
                if (want == 2'b11) m_win = m_prio;
                else               m_win = want[1] ? 1 : 0;
                m_busy      = 1;
                m_in_access = 0;
                e_psel      = 1;
                e_pen       = 0;
                e_pwrite    = write_i[m_win];
                e_paddr     = addr_i[m_win*AW +: AW];
                e_pwdata    = wdata_i[m_win*BW +: BW];
                e_pstrb     = e_pwrite ? strb_i[m_win*SW +: SW] : '0;
            end
        end else if (!m_in_access) begin
            m_in_access = 1;
            m_acc       = 0;
            e_pen       = 1;
        end else begin
            m_acc++;
            if (pready_i || m_acc == TO) begin
                e_done[m_win] = 1'b1;
                e_err   = pready_i ? pslverr_i : 1'b1;
                e_rdata = (pready_i && !e_pwrite) ? prdata_i : '0;
                m_mask  = e_done;
                m_prio  = 1 - m_win;
                m_busy  = 0;
                e_psel = 0; e_pen = 0; e_pwrite = 0; e_paddr = '0; e_pwdata = '0; e_pstrb = '0;
            end
        end
    end

    always @(negedge clk_i) begin : compare
        check("psel",    64'(psel_o),    64'(e_psel));
        check("penable", 64'(penable_o), 64'(e_pen));
        check("done",    64'(done_o),    64'(e_done));
        check("err",     64'(err_o),     64'(e_err));
        check("rdata",   64'(rdata_o),   64'(e_rdata));
        if (e_psel) begin
            check("paddr",  64'(paddr_o),  64'(e_paddr));
            check("pwrite", 64'(pwrite_o), 64'(e_pwrite));
            check("pwdata", 64'(pwdata_o), 64'(e_pwdata));
            check("pstrb",  64'(pstrb_o),  64'(e_pstrb));
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        req_i = '0; write_i = '0; addr_i = '0; wdata_i = '0; strb_i = '0;
        prdata_i = '0; pready_i = 1'b0; pslverr_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic rand_fields(input int n);
        write_i[n]          = 1'($urandom_range(0, 1));
        addr_i[n*AW +: AW]  = AW'($urandom());
        wdata_i[n*BW +: BW] = BW'($urandom());
        strb_i[n*SW +: SW]  = SW'($urandom());
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        int n_pen;
        int n_done;
        bit got_done;
        int ready_pct;
        rst_i = 1'b1;
        idle_inputs();
        tick();
        tick();
        check("reset_psel",  64'(psel_o),    64'(0));
        check("reset_pen",   64'(penable_o), 64'(0));
        check("reset_done",  64'(done_o),    64'(0));
        check("reset_rdata", 64'(rdata_o),   64'(0));
        check("reset_paddr", 64'(paddr_o),   64'(0));
        rst_i = 1'b0;

        // Single read with immediate pready.
        req_i = 2'b01; write_i = 2'b00; addr_i = {16'h0000, 16'h0010}; strb_i = 8'hFF;
        prdata_i = 32'hCAFE0001; pready_i = 1'b1;
        tick();
        check("t1_c1_psel",  64'(psel_o),    64'(1));
        check("t1_c1_pen",   64'(penable_o), 64'(0));
        check("t1_c1_paddr", 64'(paddr_o),   64'h0010);
        check("t1_c1_pstrb", 64'(pstrb_o),   64'(0));
        tick();
        check("t1_c2_pen",   64'(penable_o), 64'(1));
        tick();
        check("t1_c3_done",  64'(done_o),    64'(2'b01));
        check("t1_c3_rdata", 64'(rdata_o),   64'h0000_0000_CAFE_0001);
        check("t1_c3_err",   64'(err_o),     64'(0));
        check("t1_c3_psel",  64'(psel_o),    64'(0));
        req_i = 2'b00;
        tick();
        check("t1_c4_done",  64'(done_o),    64'(0));
        check("t1_c4_rdata", 64'(rdata_o),   64'(0));

        // Two contending writers alternate 0,1,0,1 with one deselected cycle between.
        idle_inputs();
        do_reset();
        req_i = 2'b11; write_i = 2'b11; addr_i = {16'h0008, 16'h0004};
        wdata_i = {32'h2222_2222, 32'h1111_1111}; strb_i = 8'hFF; pready_i = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            check("t2_psel", 64'(psel_o), 64'((c % 3) != 0));
            if (c % 3 == 1) begin
                check("t2_pwdata", 64'(pwdata_o), (((c - 1) / 3) % 2 == 1) ? 64'h2222_2222 : 64'h1111_1111);
                check("t2_paddr",  64'(paddr_o),  (((c - 1) / 3) % 2 == 1) ? 64'h0008 : 64'h0004);
            end
            if (c % 3 == 0)
                check("t2_done", 64'(done_o), ((c / 3 - 1) % 2 == 1) ? 64'(2'b10) : 64'(2'b01));
            if (c == 12) req_i = 2'b00;
        end
        idle_inputs();
        tick();

        // Write with three wait states, then pready with pslverr.
        req_i = 2'b10; write_i = 2'b10; addr_i = {16'h0100, 16'h0000};
        wdata_i = {32'hDEAD_BEEF, 32'h0}; strb_i = {4'h5, 4'h0};
        n_pen = 0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (penable_o) begin
                n_pen++;
                check("t3_paddr",  64'(paddr_o),  64'h0100);
                check("t3_pwdata", 64'(pwdata_o), 64'hDEAD_BEEF);
                check("t3_pstrb",  64'(pstrb_o),  64'h5);
            end
            if (c == 5) begin pready_i = 1'b1; pslverr_i = 1'b1; end
            if (c == 6) begin
                check("t3_done", 64'(done_o), 64'(2'b10));
                check("t3_err",  64'(err_o),  64'(1));
                idle_inputs();
            end
        end
        check("t3_pen_cycles", 64'(n_pen), 64'(4));

        // Read whose pready never arrives: watchdog abort.
        tick();
        req_i = 2'b01; addr_i = {16'h0000, 16'h0200}; prdata_i = 32'h1234_5678;
        n_pen = 0;
        got_done = 0;
        for (int c = 1; c <= 40 && !got_done; c++) begin
            tick();
            if (penable_o) n_pen++;
            if (done_o != 2'b00) begin
                got_done = 1;
                check("t4_done",  64'(done_o),  64'(2'b01));
                check("t4_err",   64'(err_o),   64'(1));
                check("t4_rdata", 64'(rdata_o), 64'(0));
                check("t4_psel",  64'(psel_o),  64'(0));
                req_i = 2'b00;
            end
        end
        check("t4_done_seen",  64'(got_done), 64'(1));
        check("t4_pen_cycles", 64'(n_pen),    64'(TO));

        // Reset during a wait state, then contention restarts at requester 0.
        idle_inputs();
        tick();
        req_i = 2'b01; addr_i = {16'h0000, 16'h0300};
        tick();
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("t5_psel", 64'(psel_o),    64'(0));
        check("t5_pen",  64'(penable_o), 64'(0));
        check("t5_done", 64'(done_o),    64'(0));
        check("t5_err",  64'(err_o),     64'(0));
        req_i = 2'b11; write_i = 2'b11; addr_i = {16'h0408, 16'h0404};
        wdata_i = {32'hAAAA_0001, 32'hBBBB_0002}; pready_i = 1'b1;
        tick();
        check("t5_first_paddr", 64'(paddr_o), 64'h0404);
        req_i = 2'b01;
        tick();
        tick();
        check("t5_done0", 64'(done_o), 64'(2'b01));
        idle_inputs();
        tick();

        // Requester drops req_i during SETUP; the transfer still completes once.
        req_i = 2'b01; pready_i = 1'b1;
        tick();
        req_i = 2'b00;
        n_done = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (done_o[0]) n_done++;
        end
        check("t6_done_pulses", 64'(n_done), 64'(1));

        // Random traffic against the model.
        idle_inputs();
        ready_pct = 60;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            if (psel_o && !penable_o) ready_pct = ($urandom_range(0, 9) == 0) ? 0 : 60;
            pready_i  = ($urandom_range(0, 99) < ready_pct);
            pslverr_i = ($urandom_range(0, 3) == 0);
            prdata_i  = BW'($urandom());
            for (int n = 0; n < 2; n++) begin
                if (!req_i[n]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req_i[n] = 1'b1;
                        rand_fields(n);
                    end
                end else if (done_o[n]) begin
                    if ($urandom_range(0, 1) == 0) req_i[n] = 1'b0;
                    else                           rand_fields(n);
                end else if ($urandom_range(0, 19) == 0) begin
                    rand_fields(n);
                end else if ($urandom_range(0, 49) == 0) begin
                    req_i[n] = 1'b0;
                end
            end
            rst_i = ($urandom_range(0, 499) == 0);
        end
        rst_i = 1'b0;
        idle_inputs();
        repeat (25) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
